// File: rtl/store_merge_pkg.sv
// Shared types for the read-modify-write store unit:
// size codes, FSM states and lane-geometry helpers.
package store_merge_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    ERR  = 3'd4
  } state_e;

  function automatic int lanesOf(input int dataW);
    return dataW / 8;
  endfunction

  function automatic int laneBitsOf(input int dataW);
    return $clog2(dataW / 8);
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Replaces 2^size little-endian byte lanes of a word,
// starting at lane offset, with the low bytes of newData.
module byte_lane_merge
  import store_merge_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]             oldWord,
  input  logic [DATA_W-1:0]             newData,
  input  logic [laneBitsOf(DATA_W)-1:0] offset,
  input  logic [1:0]                    size,
  output logic [DATA_W-1:0]             merged
);

  localparam int LANES = lanesOf(DATA_W);

  int off;
  int nBytes;

  always_comb begin
    off    = int'(offset);
    nBytes = 1 << size;
    merged = oldWord;
    for (int k = 0; k < LANES; k++) begin
      if (k >= off && k < off + nBytes)
        merged[8*k +: 8] = newData[8*(k-off) +: 8];
    end
  end

endmodule

// File: rtl/store_merge_rmw.sv
// Sequential store unit: sub-word stores do read/merge/write,
// aligned full words are written directly.
module store_merge_rmw
  import store_merge_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                                 Clk,
  input  logic                                 Rst,
  input  logic                                 ReqValid,
  output logic                                 ReqReady,
  input  logic [ADDR_W-1:0]                    ReqAddr,
  input  logic [DATA_W-1:0]                    ReqData,
  input  logic [1:0]                           ReqSize,
  output logic [ADDR_W-laneBitsOf(DATA_W)-1:0] MemAddr,
  output logic                                 MemRe,
  input  logic [DATA_W-1:0]                    MemRdata,
  output logic                                 MemWe,
  output logic [DATA_W-1:0]                    MemWdata,
  output logic                                 Done,
  output logic                                 Err
);

  localparam int LANES = lanesOf(DATA_W);
  localparam int LB    = laneBitsOf(DATA_W);

  state_e state, nextState;

  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] dataQ;
  logic [DATA_W-1:0] rdataQ;
  logic [1:0]        sizeQ;
  logic [DATA_W-1:0] merged;

  logic [31:0] reqBytes;
  logic        accept;
  logic        tooBig;
  logic        misalign;
  logic        reject;
  logic        full;

  assign reqBytes = 32'd1 << ReqSize;
  assign tooBig   = reqBytes > 32'(LANES);
  assign misalign = (32'(ReqAddr[LB-1:0]) & (reqBytes - 32'd1)) != 32'd0;
  assign reject   = tooBig || misalign;
  assign full     = reqBytes == 32'(LANES);
  assign accept   = ReqValid && ReqReady;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state  <= IDLE;
      addrQ  <= '0;
      dataQ  <= '0;
      sizeQ  <= '0;
      rdataQ <= '0;
    end else begin
      state <= nextState;
      if (accept) begin
        addrQ <= ReqAddr;
        dataQ <= ReqData;
        sizeQ <= ReqSize;
      end
      if (state == WAIT)
        rdataQ <= MemRdata;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (reject)
            nextState = ERR;
          else if (full)
            nextState = WR;
          else
            nextState = RD;
        end
      end
      RD:      nextState = WAIT;
      WAIT:    nextState = WR;
      WR:      nextState = IDLE;
      ERR:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // A full word covers every lane, so the stale rdataQ never leaks through.
  byte_lane_merge #(
    .DATA_W(DATA_W)
  ) uMerge (
    .oldWord(rdataQ),
    .newData(dataQ),
    .offset (addrQ[LB-1:0]),
    .size   (sizeQ),
    .merged (merged)
  );

  assign ReqReady = state == IDLE;
  assign MemRe    = state == RD;
  assign MemWe    = state == WR;
  assign Done     = state == WR;
  assign Err      = state == ERR;
  assign MemAddr  = addrQ[ADDR_W-1:LB];
  assign MemWdata = (state == WR) ? merged : '0;

endmodule

// File: tb/tb_store_merge_rmw.sv
// Scoreboard bench for store_merge_rmw: expected memory
// events are queued at accept and popped as the DUT strobes.
module tb_store_merge_rmw;

  localparam int EV_RD = 0;
  localparam int EV_WR = 1;
  localparam int EV_ER = 2;

  typedef struct {
    int          kind;
    logic [29:0] addr;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic [31:0] ReqAddr = '0;
  logic [31:0] ReqData = '0;
  logic [1:0]  ReqSize = '0;
  logic [29:0] MemAddr;
  logic        MemRe;
  logic [31:0] MemRdata = '0;
  logic        MemWe;
  logic [31:0] MemWdata;
  logic        Done;
  logic        Err;

  logic [31:0] mem [0:255];
  logic        loadEn = 1'b0;
  logic [7:0]  loadIdx = '0;
  logic [31:0] loadVal = '0;

  int  cyc = 0;
  int  nTests = 0;
  int  nFail = 0;
  ev_t sbq[$];

  store_merge_rmw #(
    .DATA_W(32),
    .ADDR_W(32)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .ReqValid(ReqValid),
    .ReqReady(ReqReady),
    .ReqAddr (ReqAddr),
    .ReqData (ReqData),
    .ReqSize (ReqSize),
    .MemAddr (MemAddr),
    .MemRe   (MemRe),
    .MemRdata(MemRdata),
    .MemWe   (MemWe),
    .MemWdata(MemWdata),
    .Done    (Done),
    .Err     (Err)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (loadEn) mem[loadIdx] <= loadVal;
    if (MemRe) MemRdata <= mem[MemAddr[7:0]];
    if (MemWe) mem[MemAddr[7:0]] <= MemWdata;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mergeRef(input logic [31:0] old,
      input logic [31:0] d, input int off, input int sz);
    logic [63:0] m;
    m = ((64'd1 << (8 << sz)) - 64'd1) << (8 * off);
    return 32'((64'(old) & ~m) | ((64'(d) << (8 * off)) & m));
  endfunction

  always @(negedge Clk) begin
    ev_t e;
    int  k;
    if (Rst) begin
      chk("exclDoneErr", 64'(Done && Err), 0);
      chk("exclReWe", 64'(MemRe && MemWe), 0);
      chk("doneIsWe", 64'(Done), 64'(MemWe));
      if (MemRe || MemWe || Err) begin
        k = MemRe ? EV_RD : (MemWe ? EV_WR : EV_ER);
        if (sbq.size() == 0) begin
          chk("unexpectedEv", 64'(k), 64'hff);
        end else begin
          e = sbq.pop_front();
          chk("evKind", 64'(k), 64'(e.kind));
          chk("evCycle", 64'(cyc), 64'(e.cyc));
          if (e.kind != EV_ER) chk("evAddr", 64'(MemAddr), 64'(e.addr));
          if (e.kind == EV_WR) chk("evWdata", 64'(MemWdata), 64'(e.data));
        end
      end
    end
  end

  task automatic push(input int kind, input logic [29:0] a,
                      input logic [31:0] d, input int c);
    ev_t e;
    e.kind = kind;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    sbq.push_back(e);
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] v);
    @(negedge Clk);
    loadEn = 1'b1;
    loadIdx = idx;
    loadVal = v;
    @(negedge Clk);
    loadEn = 1'b0;
  endtask

  task automatic toNeg(input int k);
    do @(negedge Clk); while (cyc < k);
  endtask

  task automatic sendReq(input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, output int acc);
    int n;
    n = 0;
    @(negedge Clk);
    while (!ReqReady && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (!ReqReady) chk("readyTimeout", 0, 1);
    ReqValid = 1'b1;
    ReqAddr  = a;
    ReqData  = d;
    ReqSize  = sz;
    @(posedge Clk);
    #1;
    acc = cyc;
    ReqValid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc;
    int          off;
    int          sz;
    logic [31:0] d;
    logic [31:0] ref41;

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rstReady", 64'(ReqReady), 1);
    chk("rstMemRe", 64'(MemRe), 0);
    chk("rstMemWe", 64'(MemWe), 0);
    chk("rstDone", 64'(Done), 0);
    chk("rstErr", 64'(Err), 0);
    chk("rstMemAddr", 64'(MemAddr), 0);
    chk("rstWdata", 64'(MemWdata), 0);
    Rst = 1'b1;

    preload(8'h40, 32'hAABBCCDD);
    sendReq(32'h101, 32'h12, 2'd0, acc);
    push(EV_RD, 30'h40, '0, acc);
    push(EV_WR, 30'h40, 32'hAABB12DD, acc + 2);
    toNeg(acc + 3);
    chk("sbWord", 64'(mem[8'h40]), 64'hAABB12DD);

    preload(8'h40, 32'hAABBCCDD);
    sendReq(32'h102, 32'h5678, 2'd1, acc);
    push(EV_RD, 30'h40, '0, acc);
    push(EV_WR, 30'h40, 32'h5678CCDD, acc + 2);
    toNeg(acc + 2);
    chk("shBusy", 64'(ReqReady), 0);
    toNeg(acc + 3);
    chk("shReady", 64'(ReqReady), 1);

    preload(8'h40, 32'hAABBCCDD);
    sendReq(32'h100, 32'hDEADBEEF, 2'd2, acc);
    push(EV_WR, 30'h40, 32'hDEADBEEF, acc);
    toNeg(acc + 1);
    chk("swReady", 64'(ReqReady), 1);
    chk("swWord", 64'(mem[8'h40]), 64'hDEADBEEF);

    sendReq(32'h103, 32'h1234, 2'd1, acc);
    push(EV_ER, '0, '0, acc);
    toNeg(acc + 1);
    chk("errReady", 64'(ReqReady), 1);
    sendReq(32'h100, 32'h1, 2'd3, acc);
    push(EV_ER, '0, '0, acc);
    toNeg(acc + 1);
    chk("errWordKept", 64'(mem[8'h40]), 64'hDEADBEEF);

    preload(8'h40, 32'hAABBCCDD);
    sendReq(32'h100, 32'h77, 2'd0, acc);
    push(EV_RD, 30'h40, '0, acc);
    toNeg(acc + 1);
    Rst = 1'b0;
    toNeg(acc + 2);
    chk("midRstReady", 64'(ReqReady), 1);
    chk("midRstWe", 64'(MemWe), 0);
    Rst = 1'b1;
    toNeg(acc + 3);
    chk("postRstWe", 64'(MemWe), 0);
    chk("midRstWord", 64'(mem[8'h40]), 64'hAABBCCDD);

    preload(8'h40, 32'hAABBCCDD);
    @(negedge Clk);
    ReqValid = 1'b1;
    ReqAddr  = 32'h100;
    ReqData  = 32'h11;
    ReqSize  = 2'd0;
    @(posedge Clk);
    #1;
    acc = cyc;
    ReqAddr = 32'h103;
    ReqData = 32'h22;
    push(EV_RD, 30'h40, '0, acc);
    push(EV_WR, 30'h40, 32'hAABBCC11, acc + 2);
    push(EV_RD, 30'h40, '0, acc + 4);
    push(EV_WR, 30'h40, 32'h22BBCC11, acc + 6);
    toNeg(acc + 3);
    @(posedge Clk);
    #1;
    ReqValid = 1'b0;
    toNeg(acc + 7);
    chk("b2bWord", 64'(mem[8'h40]), 64'h22BBCC11);

    ref41 = 32'h01234567;
    preload(8'h41, ref41);
    for (int i = 0; i < 8; i++) begin
      sz  = int'($urandom_range(0, 2));
      off = int'($urandom_range(0, 3)) & ~((1 << sz) - 1);
      d   = $urandom;
      sendReq(32'h104 + 32'(off), d, 2'(sz), acc);
      if (sz == 2) begin
        ref41 = d;
        push(EV_WR, 30'h41, ref41, acc);
      end else begin
        ref41 = mergeRef(ref41, d, off, sz);
        push(EV_RD, 30'h41, '0, acc);
        push(EV_WR, 30'h41, ref41, acc + 2);
      end
    end
    repeat (6) @(negedge Clk);
    chk("rndWord", 64'(mem[8'h41]), 64'(ref41));
    chk("sbDrain", 64'(sbq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
